// File: rtl/pitch_period_meter_pkg.sv
// Shared audio definitions: reference period of C1 and meter states.
// Also provides the base period used by piano_note.
package pitch_period_meter_pkg;

    localparam int unsigned BASE_CLK_PER_PERIOD = 3057805;
    localparam int unsigned NUM_OCTAVES = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        MEASURE
    } meter_state_t;

endpackage

// File: rtl/pitch_period_meter_sync_rise_detect.sv
// Two-flop synchronizer for the comparator input plus a rise detector.
// rise is a single-cycle pulse derived from the synchronized level.
module sync_rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic sig_in,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], sig_in};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/pitch_period_meter.sv
// Measures the period of a square wave averaged over four cycles and
// classifies it into one of eight octaves relative to C1.
module pitch_period_meter #(
    parameter int unsigned BASE_CLK_PER_PERIOD =
        pitch_period_meter_pkg::BASE_CLK_PER_PERIOD,
    parameter int unsigned MIN_CLKS     = 2048,
    parameter int unsigned TIMEOUT_CLKS = 6115610
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        sig_in,
    output logic [31:0] period_out,
    output logic [2:0]  octave_out,
    output logic        in_range,
    output logic        below_range,
    output logic        above_range,
    output logic        meas_valid,
    output logic        signal_present
);

    import pitch_period_meter_pkg::*;

    logic         rise;
    meter_state_t state;
    meter_state_t state_nx;
    logic [31:0]  cnt;
    logic [33:0]  acc;
    logic [1:0]   idx;
    logic [33:0]  sum;
    logic [31:0]  p_new;
    logic         timeout;
    logic         accept;
    logic         start;
    logic [2:0]   oct_nx;
    logic         in_nx;
    logic         below_nx;
    logic         above_nx;

    sync_rise_detect u_sync (
        .clk    (clk),
        .resetn (resetn),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // cnt holds cycles elapsed since the last accepted edge
    assign timeout = (state != IDLE) && (cnt == TIMEOUT_CLKS);
    assign accept  = rise && (cnt >= MIN_CLKS);
    assign start   = rise && ((state == IDLE) || timeout);
    assign sum     = acc + {2'b00, cnt};
    assign p_new   = sum[33:2];

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) state_nx = ACQUIRE;
                end
                ACQUIRE, MEASURE: begin
                    if (timeout) begin
                        state_nx = rise ? ACQUIRE : IDLE;
                    end else if (accept) begin
                        state_nx = MEASURE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        oct_nx   = 3'd0;
        in_nx    = 1'b0;
        below_nx = 1'b0;
        above_nx = 1'b0;
        if (p_new > BASE_CLK_PER_PERIOD) begin
            below_nx = 1'b1;
        end else if (p_new <= (BASE_CLK_PER_PERIOD >> NUM_OCTAVES)) begin
            above_nx = 1'b1;
            oct_nx   = 3'd7;
        end else begin
            in_nx = 1'b1;
            for (int k = 0; k < NUM_OCTAVES; k++) begin
                if (p_new >  (BASE_CLK_PER_PERIOD >> (k + 1)) &&
                    p_new <= (BASE_CLK_PER_PERIOD >> k)) begin
                    oct_nx = 3'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt            <= '0;
            acc            <= '0;
            idx            <= '0;
            period_out     <= '0;
            octave_out     <= '0;
            in_range       <= 1'b0;
            below_range    <= 1'b0;
            above_range    <= 1'b0;
            meas_valid     <= 1'b0;
            signal_present <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                cnt            <= '0;
                acc            <= '0;
                idx            <= '0;
                signal_present <= 1'b0;
            end else if (start) begin
                cnt            <= 32'd1;
                acc            <= '0;
                idx            <= '0;
                signal_present <= 1'b0;
            end else if (timeout) begin
                acc            <= '0;
                signal_present <= 1'b0;
            end else if (state != IDLE && accept) begin
                cnt <= 32'd1;
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    acc            <= '0;
                    meas_valid     <= 1'b1;
                    signal_present <= 1'b1;
                    period_out     <= p_new;
                    octave_out     <= oct_nx;
                    in_range       <= in_nx;
                    below_range    <= below_nx;
                    above_range    <= above_nx;
                end else begin
                    acc <= sum;
                end
            end else if (cnt != TIMEOUT_CLKS) begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/pitch_period_meter.md
PITCH_PERIOD_METER -- requirements
Module: pitch_period_meter

Interface
REQ-001 SHALL have parameter BASE_CLK_PER_PERIOD, default 3057805, meaning the clocks per period of C1, octave 0 reference.
REQ-002 SHALL have parameter MIN_CLKS, default 2048, meaning the shortest accepted period; rising edges arriving earlier are glitches.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 6115610, meaning clocks without an accepted edge before the signal is declared lost.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low, on clock clk.
REQ-006 SHALL have port enable, input, 1 bit: measurement enable.
REQ-007 SHALL have port sig_in, input, 1 bit: asynchronous square wave from the mic comparator.
REQ-008 SHALL have port period_out, output, 32 bits: averaged period in clk cycles.
REQ-009 SHALL have port octave_out, output, 3 bits: detected octave 0..7.
REQ-010 SHALL have ports in_range, below_range and above_range, output, 1 bit each: classification flags, exactly one high after the first measurement.
REQ-011 SHALL have port meas_valid, output, 1 bit: one-cycle strobe when new results are presented.
REQ-012 SHALL have port signal_present, output, 1 bit: a tone is currently being tracked.

Function
REQ-013 SHALL synchronize sig_in through 2 flops, then register it once more for rising-edge detect, giving a 1-cycle rise pulse 3 cycles after the input edge.
REQ-014 SHALL define period as the clk-cycle distance between two accepted rise pulses (pulses at cycles 0 and 100 give 100).
REQ-015 SHALL ignore a rise pulse when fewer than MIN_CLKS cycles have elapsed since the last accepted one; the counter continues unchanged.
REQ-016 SHALL use FSM states IDLE, ACQUIRE and MEASURE.
REQ-017 SHALL move IDLE->ACQUIRE on the first rise pulse while enable is high, clearing the counter, the accumulator and the period index.
REQ-018 SHALL, in ACQUIRE or MEASURE, on each accepted edge add the period to a 34-bit accumulator and increment a 2-bit period index; ACQUIRE->MEASURE on the first accepted edge.
REQ-019 SHALL, on the accepted edge that completes 4 periods, assert meas_valid in the next cycle and update all result outputs in that same cycle.
REQ-020 SHALL compute period_out as (sum of 4 periods) >> 2, truncating, then clear the accumulator and continue measuring without gaps.
REQ-021 SHALL classify period P:
  - octave_out = k where (BASE >> (k+1)) < P <= (BASE >> k), k = 0..7, giving in_range=1.
  - P > BASE: below_range=1, octave_out=0.
  - P <= BASE >> 8: above_range=1, octave_out=7.
REQ-022 SHALL set signal_present with the first meas_valid and keep it high until timeout, enable low or reset.
REQ-023 SHALL, in ACQUIRE or MEASURE, go to IDLE when the counter reaches TIMEOUT_CLKS, clearing signal_present and the accumulator, giving no meas_valid, and holding the result outputs.
REQ-024 SHALL give timeout priority over a rise pulse in the same cycle; that pulse SHALL then act as the IDLE->ACQUIRE first edge.
REQ-025 SHALL, when enable is low, force IDLE, clear the counter, accumulator and signal_present, and hold the result outputs.
REQ-026 SHALL saturate the period counter at TIMEOUT_CLKS so it never wraps.

Reset
REQ-027 SHALL, on reset, clear the synchronizer flops, counter, accumulator, FSM (IDLE), period_out, octave_out, all three range flags, meas_valid and signal_present to 0.
REQ-028 SHALL, when reset occurs mid-measurement, discard the partial sum and produce no meas_valid until 4 full periods are measured after release.

Structure
REQ-029 SHALL keep the FSM state enum, the default BASE_CLK_PER_PERIOD and NUM_OCTAVES=8 in the shared audio package, which piano_note also uses for its base period.
REQ-030 SHALL put the synchronizer plus edge detect in one sub-module, sync_rise_detect; classification SHALL be inline compare logic against 8 shifted constants.

Verification
Bench parameters: BASE=30578, MIN_CLKS=64, TIMEOUT_CLKS=61156.
REQ-031 SHALL verify: 5 rises, period 30578 -> one meas_valid, period_out=30578, octave_out=0, in_range=1, signal_present=1.
REQ-032 SHALL verify: periods 3800,3810,3820,3830 -> period_out=3815, octave_out=3, in_range=1.
REQ-033 SHALL verify: period 3822 with a 10-cycle glitch pulse 30 cycles after each edge -> glitches ignored, period_out=3822.
REQ-034 SHALL verify: period 40000 -> below_range=1, octave_out=0; then period 100 -> above_range=1, octave_out=7.
REQ-035 SHALL verify: toggling stops after a valid measurement -> signal_present falls exactly 61156 cycles after the last accepted edge, and outputs hold.
REQ-036 SHALL verify: resetn low after 2 periods -> all outputs 0; the first meas_valid appears only after 5 new rises.
